// File: rtl/ysyx_rd_arb.sv
// Read-channel arbiter: shares one AXI4 read master between the IFU (bursts,
// optional lock) and the LSU (single beats), with one transaction in flight.
module ysyx_rd_arb #(
  parameter int XLEN       = 32,
  parameter int IFU_BLEN   = 3,
  parameter int STARVE_MAX = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush_pipeline,
  input  logic            ifu_arvalid,
  input  logic [XLEN-1:0] ifu_araddr,
  input  logic            ifu_lock,
  input  logic            ifu_ready,
  output logic            out_ifu_arready,
  output logic [XLEN-1:0] out_ifu_rdata,
  output logic            out_ifu_rvalid,
  output logic            out_ifu_rlast,
  output logic            out_ifu_rerr,
  input  logic            lsu_arvalid,
  input  logic [XLEN-1:0] lsu_araddr,
  input  logic [2:0]      lsu_arsize,
  output logic            out_lsu_arready,
  output logic [XLEN-1:0] out_lsu_rdata,
  output logic            out_lsu_rvalid,
  output logic            out_lsu_rerr,
  output logic [XLEN-1:0] io_master_araddr,
  output logic            io_master_arvalid,
  input  logic            io_master_arready,
  output logic [7:0]      io_master_arlen,
  output logic [2:0]      io_master_arsize,
  output logic [1:0]      io_master_arburst,
  output logic [3:0]      io_master_arid,
  input  logic [XLEN-1:0] io_master_rdata,
  input  logic            io_master_rvalid,
  output logic            io_master_rready,
  input  logic [1:0]      io_master_rresp,
  input  logic            io_master_rlast,
  input  logic [3:0]      io_master_rid,
  output logic [2:0]      o_dbg_state,
  output logic [4:0]      o_dbg_starve_cnt
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never drops and its payload never changes until then.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_AR_IFU = 3'd1,
    S_AR_LSU = 3'd2,
    S_R_IFU  = 3'd3,
    S_R_LSU  = 3'd4,
    S_DRAIN  = 3'd5
  } state_t;

  localparam logic [4:0] LP_STARVE_MAX = 5'(STARVE_MAX);

  state_t          r_state;
  logic [4:0]      r_starve_cnt;
  logic [XLEN-1:0] r_addr;
  logic [2:0]      r_size;
  logic            r_flush_pend;

  logic w_idle;
  logic w_ifu_lock_win;
  logic w_grant_ifu;
  logic w_grant_lsu;
  logic w_r_hs;

  assign w_idle         = (r_state == S_IDLE) && reset;
  assign w_ifu_lock_win = w_idle && !flush_pipeline && ifu_lock && ifu_arvalid &&
                          (r_starve_cnt < LP_STARVE_MAX);
  assign w_grant_lsu    = w_idle && !w_ifu_lock_win && lsu_arvalid;
  assign w_grant_ifu    = w_ifu_lock_win ||
                          (w_idle && !lsu_arvalid && !flush_pipeline && ifu_arvalid);
  assign w_r_hs         = io_master_rvalid && io_master_rready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= 5'd0;
      r_addr       <= '0;
      r_size       <= 3'd0;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_grant_lsu)
        r_starve_cnt <= 5'd0;
      else if (lsu_arvalid && (r_starve_cnt < LP_STARVE_MAX))
        r_starve_cnt <= r_starve_cnt + 5'd1;

      case (r_state)
        S_IDLE: begin
          r_flush_pend <= 1'b0;
          if (w_grant_ifu) begin
            r_addr  <= ifu_araddr;
            r_size  <= 3'b010;
            r_state <= S_AR_IFU;
          end else if (w_grant_lsu) begin
            r_addr  <= lsu_araddr;
            r_size  <= lsu_arsize;
            r_state <= S_AR_LSU;
          end
        end
        // A flush seen while the address is still pending is remembered so
        // the accepted burst is drained rather than forwarded.
        S_AR_IFU: begin
          if (io_master_arready) begin
            r_state      <= (flush_pipeline || r_flush_pend) ? S_DRAIN : S_R_IFU;
            r_flush_pend <= 1'b0;
          end else if (flush_pipeline) begin
            r_flush_pend <= 1'b1;
          end
        end
        S_AR_LSU: if (io_master_arready) r_state <= S_R_LSU;
        S_R_IFU: begin
          if (w_r_hs && io_master_rlast) r_state <= S_IDLE;
          else if (flush_pipeline)       r_state <= S_DRAIN;
        end
        S_R_LSU:  if (io_master_rvalid && io_master_rlast) r_state <= S_IDLE;
        S_DRAIN:  if (io_master_rvalid && io_master_rlast) r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    out_ifu_arready   = w_grant_ifu;
    out_lsu_arready   = w_grant_lsu;
    out_ifu_rdata     = '0;
    out_ifu_rvalid    = 1'b0;
    out_ifu_rlast     = 1'b0;
    out_ifu_rerr      = 1'b0;
    out_lsu_rdata     = '0;
    out_lsu_rvalid    = 1'b0;
    out_lsu_rerr      = 1'b0;
    io_master_araddr  = '0;
    io_master_arvalid = 1'b0;
    io_master_arlen   = 8'd0;
    io_master_arsize  = 3'd0;
    io_master_arburst = 2'b00;
    io_master_arid    = 4'd0;
    io_master_rready  = 1'b0;
    case (r_state)
      S_AR_IFU: begin
        io_master_arvalid = 1'b1;
        io_master_araddr  = r_addr;
        io_master_arlen   = 8'(IFU_BLEN);
        io_master_arsize  = 3'b010;
        io_master_arburst = 2'b01;
        io_master_arid    = 4'd0;
      end
      S_AR_LSU: begin
        io_master_arvalid = 1'b1;
        io_master_araddr  = r_addr;
        io_master_arlen   = 8'd0;
        io_master_arsize  = r_size;
        io_master_arburst = 2'b01;
        io_master_arid    = 4'd1;
      end
      // A beat carrying the other requester's id is still consumed but flagged.
      S_R_IFU: begin
        io_master_rready = ifu_ready;
        out_ifu_rvalid   = io_master_rvalid;
        out_ifu_rdata    = io_master_rdata;
        out_ifu_rlast    = io_master_rlast;
        out_ifu_rerr     = (io_master_rresp != 2'b00) || (io_master_rid != 4'd0);
      end
      S_R_LSU: begin
        io_master_rready = 1'b1;
        out_lsu_rvalid   = io_master_rvalid;
        out_lsu_rdata    = io_master_rdata;
        out_lsu_rerr     = (io_master_rresp != 2'b00) || (io_master_rid != 4'd1);
      end
      S_DRAIN: io_master_rready = 1'b1;
      default: ;
    endcase
  end

  assign o_dbg_state      = r_state;
  assign o_dbg_starve_cnt = r_starve_cnt;

endmodule

// File: tb/tb_ysyx_rd_arb.sv
// Bench for ysyx_rd_arb: a table of IDLE grant decisions, then hand-written
// sequences for bursts, flush, starvation override and mid-burst reset.
module tb_ysyx_rd_arb;

  localparam int XLEN = 32;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_AR_IFU = 3'd1;
  localparam logic [2:0] ST_R_IFU  = 3'd3;
  localparam logic [2:0] ST_R_LSU  = 3'd4;
  localparam logic [2:0] ST_DRAIN  = 3'd5;

  logic            clock = 1'b0;
  logic            reset;
  logic            flush_pipeline;
  logic            ifu_arvalid, ifu_lock, ifu_ready;
  logic [XLEN-1:0] ifu_araddr;
  logic            out_ifu_arready, out_ifu_rvalid, out_ifu_rlast, out_ifu_rerr;
  logic [XLEN-1:0] out_ifu_rdata;
  logic            lsu_arvalid;
  logic [XLEN-1:0] lsu_araddr;
  logic [2:0]      lsu_arsize;
  logic            out_lsu_arready, out_lsu_rvalid, out_lsu_rerr;
  logic [XLEN-1:0] out_lsu_rdata;
  logic [XLEN-1:0] io_master_araddr, io_master_rdata;
  logic            io_master_arvalid, io_master_arready, io_master_rvalid;
  logic            io_master_rready, io_master_rlast;
  logic [7:0]      io_master_arlen;
  logic [2:0]      io_master_arsize;
  logic [1:0]      io_master_arburst, io_master_rresp;
  logic [3:0]      io_master_arid, io_master_rid;
  logic [2:0]      o_dbg_state;
  logic [4:0]      o_dbg_starve_cnt;

  ysyx_rd_arb #(.XLEN(XLEN), .IFU_BLEN(3), .STARVE_MAX(15)) dut (
    .clock(clock), .reset(reset), .flush_pipeline(flush_pipeline),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_lock(ifu_lock),
    .ifu_ready(ifu_ready), .out_ifu_arready(out_ifu_arready),
    .out_ifu_rdata(out_ifu_rdata), .out_ifu_rvalid(out_ifu_rvalid),
    .out_ifu_rlast(out_ifu_rlast), .out_ifu_rerr(out_ifu_rerr),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize),
    .out_lsu_arready(out_lsu_arready), .out_lsu_rdata(out_lsu_rdata),
    .out_lsu_rvalid(out_lsu_rvalid), .out_lsu_rerr(out_lsu_rerr),
    .io_master_araddr(io_master_araddr), .io_master_arvalid(io_master_arvalid),
    .io_master_arready(io_master_arready), .io_master_arlen(io_master_arlen),
    .io_master_arsize(io_master_arsize), .io_master_arburst(io_master_arburst),
    .io_master_arid(io_master_arid), .io_master_rdata(io_master_rdata),
    .io_master_rvalid(io_master_rvalid), .io_master_rready(io_master_rready),
    .io_master_rresp(io_master_rresp), .io_master_rlast(io_master_rlast),
    .io_master_rid(io_master_rid), .o_dbg_state(o_dbg_state),
    .o_dbg_starve_cnt(o_dbg_starve_cnt)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int n_run  = 0;
  int n_fail = 0;
  logic [XLEN-1:0] exp_q[$];

  typedef struct {
    logic        ifu_v, ifu_lk, lsu_v, flush;
    logic [31:0] ifu_addr, lsu_addr;
    logic [2:0]  lsu_size;
    logic        exp_ifu_rdy, exp_lsu_rdy, exp_arvalid;
    logic [31:0] exp_araddr;
    logic [7:0]  exp_arlen;
    logic [2:0]  exp_arsize;
    logic [3:0]  exp_arid;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic any_out();
    return |{out_ifu_arready, out_ifu_rdata, out_ifu_rvalid, out_ifu_rlast, out_ifu_rerr,
             out_lsu_arready, out_lsu_rdata, out_lsu_rvalid, out_lsu_rerr,
             io_master_araddr, io_master_arvalid, io_master_arlen, io_master_arsize,
             io_master_arburst, io_master_arid, io_master_rready};
  endfunction

  // driver tasks
  task automatic slave_idle();
    io_master_rvalid = 1'b0;
    io_master_rdata  = '0;
    io_master_rlast  = 1'b0;
    io_master_rresp  = 2'b00;
    io_master_rid    = 4'd0;
  endtask

  task automatic beat(input logic [31:0] d, input logic last, input logic [1:0] resp,
                      input logic [3:0] id);
    io_master_rvalid = 1'b1;
    io_master_rdata  = d;
    io_master_rlast  = last;
    io_master_rresp  = resp;
    io_master_rid    = id;
  endtask

  task automatic clear_inputs();
    flush_pipeline    = 1'b0;
    ifu_arvalid       = 1'b0;
    ifu_lock          = 1'b0;
    ifu_ready         = 1'b1;
    ifu_araddr        = '0;
    lsu_arvalid       = 1'b0;
    lsu_araddr        = '0;
    lsu_arsize        = 3'd0;
    io_master_arready = 1'b0;
    slave_idle();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // Grant an IFU request at addr and let the address phase complete at once.
  task automatic ifu_grant_and_ar(input logic [31:0] addr);
    ifu_arvalid = 1'b1;
    ifu_araddr  = addr;
    #1 check("ifu_grant_pulse", out_ifu_arready, 1'b1);
    @(negedge clock);
    ifu_arvalid = 1'b0;
    io_master_arready = 1'b1;
    #1 check("ifu_ar_addr", io_master_araddr, addr);
    @(negedge clock);
    io_master_arready = 1'b0;
  endtask

  initial begin
    vec_t v;
    logic [31:0] d;
    int ifu_grants;
    int beat_n;
    logic [4:0] cnt_at;
    logic lsu_seen;

    reset = 1'b0;
    clear_inputs();

    //                ifu lk lsu fl  ifu_addr      lsu_addr      sz   ir lr av  araddr        len   sz    id
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h3000_0000, 32'h0,         3'd0, 1'b1, 1'b0, 1'b1, 32'h3000_0000, 8'd3, 3'd2, 4'd0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h3000_0040, 32'h8000_0010, 3'd1, 1'b0, 1'b1, 1'b1, 32'h8000_0010, 8'd0, 3'd1, 4'd1};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h3000_0080, 32'h8000_0020, 3'd2, 1'b1, 1'b0, 1'b1, 32'h3000_0080, 8'd3, 3'd2, 4'd0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_0004, 3'd0, 1'b0, 1'b1, 1'b1, 32'h0000_0004, 8'd0, 3'd0, 4'd1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h3000_00c0, 32'h0,         3'd0, 1'b0, 1'b0, 1'b0, 32'h0,         8'd0, 3'd0, 4'd0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h3000_0100, 32'h8000_0030, 3'd2, 1'b0, 1'b1, 1'b1, 32'h8000_0030, 8'd0, 3'd2, 4'd1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         3'd0, 1'b0, 1'b0, 1'b0, 32'h0,         8'd0, 3'd0, 4'd0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hdead_beec, 32'h0,         3'd0, 1'b1, 1'b0, 1'b1, 32'hdead_beec, 8'd3, 3'd2, 4'd0};

    // reset state
    repeat (2) @(negedge clock);
    #1 check("reset_outputs_zero", any_out(), 1'b0);
    check("reset_state", o_dbg_state, ST_IDLE);
    check("reset_starve_cnt", o_dbg_starve_cnt, 5'd0);
    reset = 1'b1;
    @(negedge clock);
    #1 check("idle_outputs_zero", any_out(), 1'b0);

    // table: IDLE grant decision and the address phase it produces
    for (int i = 0; i < 8; i++) begin
      do_reset();
      v = vecs[i];
      ifu_arvalid    = v.ifu_v;
      ifu_lock       = v.ifu_lk;
      lsu_arvalid    = v.lsu_v;
      flush_pipeline = v.flush;
      ifu_araddr     = v.ifu_addr;
      lsu_araddr     = v.lsu_addr;
      lsu_arsize     = v.lsu_size;
      #1;
      check($sformatf("v%0d_ifu_arready", i), out_ifu_arready, v.exp_ifu_rdy);
      check($sformatf("v%0d_lsu_arready", i), out_lsu_arready, v.exp_lsu_rdy);
      @(negedge clock);
      clear_inputs();
      #1;
      check($sformatf("v%0d_arvalid", i), io_master_arvalid, v.exp_arvalid);
      check($sformatf("v%0d_araddr", i), io_master_araddr, v.exp_araddr);
      check($sformatf("v%0d_arlen", i), io_master_arlen, v.exp_arlen);
      check($sformatf("v%0d_arsize", i), io_master_arsize, v.exp_arsize);
      check($sformatf("v%0d_arid", i), io_master_arid, v.exp_arid);
      check($sformatf("v%0d_arburst", i), io_master_arburst, v.exp_arvalid ? 2'b01 : 2'b00);
      check($sformatf("v%0d_arready_pulse_end", i), out_ifu_arready | out_lsu_arready, 1'b0);
    end

    // IFU burst with 5-cycle AR stall and one beat of IFU backpressure
    do_reset();
    ifu_arvalid = 1'b1;
    ifu_araddr  = 32'h3000_0000;
    #1 check("burst_grant", out_ifu_arready, 1'b1);
    @(negedge clock);
    ifu_arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_arvalid", io_master_arvalid, 1'b1);
      check("stall_araddr", io_master_araddr, 32'h3000_0000);
      check("stall_arlen", io_master_arlen, 8'd3);
      @(negedge clock);
    end
    io_master_arready = 1'b1;
    #1 check("stall_arid", io_master_arid, 4'd0);
    @(negedge clock);
    io_master_arready = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'ha000_0000 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      beat(32'ha000_0000 + 32'(i), i == 3, 2'b00, 4'd0);
      if (i == 2) begin
        ifu_ready = 1'b0;
        #1 check("bp_rready_low", io_master_rready, 1'b0);
        @(negedge clock);
        ifu_ready = 1'b1;
      end
      #1;
      d = exp_q.pop_front();
      check("burst_rready", io_master_rready, 1'b1);
      check("burst_rvalid", out_ifu_rvalid, 1'b1);
      check("burst_rdata", out_ifu_rdata, d);
      check("burst_rlast", out_ifu_rlast, i == 3);
      check("burst_rerr", out_ifu_rerr, 1'b0);
      @(negedge clock);
    end
    slave_idle();
    #1 check("burst_back_idle", o_dbg_state, ST_IDLE);

    // LSU beats IFU without lock; error response; IFU served afterward
    do_reset();
    ifu_arvalid = 1'b1;
    ifu_araddr  = 32'h3000_0200;
    lsu_arvalid = 1'b1;
    lsu_araddr  = 32'h8000_0100;
    lsu_arsize  = 3'd2;
    #1;
    check("pri_lsu_arready", out_lsu_arready, 1'b1);
    check("pri_ifu_arready", out_ifu_arready, 1'b0);
    @(negedge clock);
    lsu_arvalid = 1'b0;
    io_master_arready = 1'b1;
    #1;
    check("pri_lsu_arid", io_master_arid, 4'd1);
    check("pri_lsu_arlen", io_master_arlen, 8'd0);
    check("pri_lsu_araddr", io_master_araddr, 32'h8000_0100);
    @(negedge clock);
    io_master_arready = 1'b0;
    beat(32'h1234_5678, 1'b1, 2'b10, 4'd1);
    #1;
    check("lsu_rvalid", out_lsu_rvalid, 1'b1);
    check("lsu_rerr", out_lsu_rerr, 1'b1);
    check("lsu_rdata", out_lsu_rdata, 32'h1234_5678);
    check("lsu_rready", io_master_rready, 1'b1);
    check("lsu_no_ifu_rvalid", out_ifu_rvalid, 1'b0);
    @(negedge clock);
    slave_idle();
    #1 check("ifu_after_lsu_grant", out_ifu_arready, 1'b1);
    @(negedge clock);
    ifu_arvalid = 1'b0;
    io_master_arready = 1'b1;
    #1 check("ifu_after_lsu_arlen", io_master_arlen, 8'd3);
    @(negedge clock);
    io_master_arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat(32'hb000_0000 + 32'(i), i == 3, 2'b00, (i == 0) ? 4'd1 : 4'd0);
      #1 check("rid_mismatch_rerr", out_ifu_rerr, i == 0);
      @(negedge clock);
    end
    slave_idle();
    #1 check("ifu_after_lsu_idle", o_dbg_state, ST_IDLE);

    // flush during the first data beat
    do_reset();
    ifu_grant_and_ar(32'h3000_0300);
    beat(32'hc000_0000, 1'b0, 2'b00, 4'd0);
    flush_pipeline = 1'b1;
    #1 check("flush_beat1_fwd", out_ifu_rvalid, 1'b1);
    @(negedge clock);
    flush_pipeline = 1'b0;
    ifu_ready = 1'b0;
    for (int i = 1; i < 4; i++) begin
      beat(32'hc000_0000 + 32'(i), i == 3, 2'b00, 4'd0);
      #1;
      check("drain_state", o_dbg_state, ST_DRAIN);
      check("drain_rready", io_master_rready, 1'b1);
      check("drain_no_rvalid", out_ifu_rvalid, 1'b0);
      @(negedge clock);
    end
    slave_idle();
    #1 check("drain_back_idle", o_dbg_state, ST_IDLE);

    // flush while the address is still waiting for arready
    do_reset();
    ifu_arvalid = 1'b1;
    ifu_araddr  = 32'h3000_0400;
    @(negedge clock);
    ifu_arvalid = 1'b0;
    flush_pipeline = 1'b1;
    #1 check("ar_flush_keeps_arvalid", io_master_arvalid, 1'b1);
    @(negedge clock);
    flush_pipeline = 1'b0;
    io_master_arready = 1'b1;
    #1 check("ar_flush_still_ar", o_dbg_state, ST_AR_IFU);
    @(negedge clock);
    io_master_arready = 1'b0;
    #1 check("ar_flush_to_drain", o_dbg_state, ST_DRAIN);
    for (int i = 0; i < 4; i++) begin
      beat(32'h0, i == 3, 2'b00, 4'd0);
      @(negedge clock);
    end
    slave_idle();
    #1 check("ar_flush_idle", o_dbg_state, ST_IDLE);

    // locked IFU starves a waiting LSU until the counter saturates
    do_reset();
    ifu_arvalid = 1'b1;
    ifu_lock    = 1'b1;
    ifu_araddr  = 32'h3000_0500;
    lsu_arvalid = 1'b1;
    lsu_araddr  = 32'h8000_0200;
    io_master_arready = 1'b1;
    ifu_grants = 0;
    beat_n     = 0;
    lsu_seen   = 1'b0;
    cnt_at     = 5'd0;
    for (int c = 0; c < 200 && !lsu_seen; c++) begin
      if (o_dbg_state == ST_R_IFU) beat(32'h0, beat_n == 3, 2'b00, 4'd0);
      else if (o_dbg_state == ST_R_LSU) beat(32'h0, 1'b1, 2'b00, 4'd1);
      else slave_idle();
      #1;
      if (out_ifu_arready) ifu_grants++;
      if (out_lsu_arready) begin
        lsu_seen = 1'b1;
        cnt_at   = o_dbg_starve_cnt;
      end
      if (o_dbg_state == ST_R_IFU && io_master_rvalid && io_master_rready)
        beat_n = (beat_n == 3) ? 0 : beat_n + 1;
      @(negedge clock);
    end
    check("starve_lsu_granted", lsu_seen, 1'b1);
    check("starve_ifu_grants", ifu_grants, 3);
    check("starve_cnt_at_grant", cnt_at, 5'd15);
    lsu_arvalid = 1'b0;
    #1 check("starve_cnt_cleared", o_dbg_starve_cnt, 5'd0);

    // reset in the middle of an IFU burst
    do_reset();
    ifu_grant_and_ar(32'h3000_0600);
    beat(32'hd000_0000, 1'b0, 2'b00, 4'd0);
    #1 check("rst_mid_beat_fwd", out_ifu_rvalid, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    slave_idle();
    ifu_arvalid = 1'b1;
    @(negedge clock);
    #1;
    check("rst_mid_state", o_dbg_state, ST_IDLE);
    check("rst_mid_outputs_zero", any_out(), 1'b0);
    reset = 1'b1;
    ifu_arvalid = 1'b0;
    beat(32'hd000_0001, 1'b0, 2'b00, 4'd0);
    @(negedge clock);
    #1;
    check("rst_mid_no_forward", out_ifu_rvalid, 1'b0);
    check("rst_mid_no_rready", io_master_rready, 1'b0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_rd_arb.md
YSYX_RD_ARB -- requirements
Module: ysyx_rd_arb

Interface
REQ-001 SHALL have parameter XLEN, default 32: address/data width.
REQ-002 SHALL have parameter IFU_BLEN, default 3: IFU burst arlen (beats-1).
REQ-003 SHALL have parameter STARVE_MAX, default 15: LSU wait-cycle limit before a locked IFU is overridden.
REQ-004 SHALL have ports: clock  in  1  sole clock; reset  in  1  synchronous, active-low.
REQ-005 SHALL have ports: flush_pipeline  in  1  discard the in-flight IFU fetch.
REQ-006 SHALL have IFU ports: ifu_arvalid in 1; ifu_araddr in XLEN; ifu_lock in 1 (request back-to-back grant); ifu_ready in 1 (IFU accepts beat); out_ifu_arready out 1; out_ifu_rdata out XLEN; out_ifu_rvalid out 1; out_ifu_rlast out 1; out_ifu_rerr out 1.
REQ-007 SHALL have LSU ports: lsu_arvalid in 1; lsu_araddr in XLEN; lsu_arsize in 3; out_lsu_arready out 1; out_lsu_rdata out XLEN; out_lsu_rvalid out 1; out_lsu_rerr out 1.
REQ-008 SHALL have AXI4 master read ports: io_master_araddr out XLEN; io_master_arvalid out 1; io_master_arready in 1; io_master_arlen out 8; io_master_arsize out 3; io_master_arburst out 2; io_master_arid out 4; io_master_rdata in XLEN; io_master_rvalid in 1; io_master_rready out 1; io_master_rresp in 2; io_master_rlast in 1; io_master_rid in 4.

Function
REQ-009 SHALL implement FSM states IDLE, AR_IFU, AR_LSU, R_IFU, R_LSU, DRAIN; one outstanding AXI transaction maximum.
REQ-010 IDLE grant order SHALL be: (ifu_lock && ifu_arvalid && starve_cnt<STARVE_MAX) -> AR_IFU; else lsu_arvalid -> AR_LSU; else ifu_arvalid -> AR_IFU; else stay IDLE.
REQ-011 On grant, out_*_arready SHALL pulse high exactly one cycle (IDLE cycle of decision); address/size SHALL be latched that cycle.
REQ-012 AR_IFU SHALL drive arvalid=1, latched addr, arlen=IFU_BLEN, arsize=3'b010, arburst=2'b01 (INCR), arid=0; on arready -> R_IFU.
REQ-013 AR_LSU SHALL drive arvalid=1, latched addr, arlen=0, arsize=latched lsu_arsize, arburst=2'b01, arid=1; on arready -> R_LSU.
REQ-014 AR address/controls SHALL remain stable while arvalid=1 and arready=0.
REQ-015 R_IFU SHALL drive rready=ifu_ready, out_ifu_rvalid=rvalid, out_ifu_rdata=rdata, out_ifu_rlast=rlast, out_ifu_rerr=(rresp!=0), combinationally; on rvalid&&rready&&rlast -> IDLE.
REQ-016 R_LSU SHALL drive rready=1, out_lsu_rvalid=rvalid, out_lsu_rdata=rdata, out_lsu_rerr=(rresp!=0); on rvalid&&rlast -> IDLE.
REQ-017 flush_pipeline in AR_IFU SHALL NOT drop arvalid (AXI rule); on arready -> DRAIN instead of R_IFU.
REQ-018 flush_pipeline in R_IFU SHALL -> DRAIN next cycle; the flush-cycle beat itself is still forwarded.
REQ-019 DRAIN SHALL drive rready=1, out_ifu_rvalid=0, and on rvalid&&rlast -> IDLE.
REQ-020 flush_pipeline SHALL NOT affect AR_LSU/R_LSU; flush in IDLE SHALL suppress IFU grant that cycle.
REQ-021 starve_cnt (5-bit) SHALL increment each cycle lsu_arvalid=1 and LSU not granted, saturate at STARVE_MAX, clear on LSU grant.
REQ-022 Beats whose rid mismatches the active grant SHALL still be accepted per state rules and flag out_*_rerr=1 on that beat.
REQ-023 All outputs not driven by the active state SHALL be 0.

Reset
REQ-024 reset=0 at a clock edge SHALL force IDLE, starve_cnt=0, latched addr/size=0, all outputs 0 next cycle.
REQ-025 Reset mid-transaction SHALL abandon it; no beat forwarded afterward; downstream AXI slave is reset concurrently.

Verification
REQ-026 IFU only, addr 0x3000_0000, no lock -> AR arlen=3, arid=0, arburst=1; 4 beats forwarded, rlast on 4th, back to IDLE.
REQ-027 IFU and LSU valid same IDLE cycle, ifu_lock=0 -> LSU granted, arlen=0, arid=1; IFU granted after LSU rlast.
REQ-028 ifu_lock=1 with LSU waiting, IFU re-requests every IDLE -> IFU wins until starve_cnt=15, then LSU granted, cnt=0.
REQ-029 flush_pipeline after beat 1 of IFU burst -> beat 1 forwarded, beats 2-4 accepted with rready=1, out_ifu_rvalid=0, IDLE after rlast.
REQ-030 LSU read, rresp=2'b10 -> out_lsu_rvalid=1 with out_lsu_rerr=1 same cycle.
REQ-031 arready held 0 for 5 cycles in AR_IFU -> araddr/arlen stable, arvalid=1 throughout; reset=0 in R_IFU -> IDLE, outputs 0.
